// File: rtl/clock_phase_gen.sv
// clock_phase_gen: phase-aligned clock enables, core reset stretch and
// run/halt control at instruction boundaries for the processor top level.
// Optional single-step support is compiled in with `define CLOCK_PHASE_GEN_STEP_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HOLD    | core reset stretched after board reset, enables off
// HALTED  | idle at an instruction boundary, phase held at 0
// RUN     | free-running instructions, PHASES cycles each
// STEP    | exactly one instruction, then back to HALTED (optional)
module clock_phase_gen #(
  parameter int PHASES   = 4,
  parameter int RST_HOLD = 8,
  parameter int CYC_W    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      run_req,
  input  logic                      halt_req,
  input  logic                      step_req,
  output logic                      core_reset,
  output logic                      imem_clk_en,
  output logic                      dmem_clk_en,
  output logic                      regfile_clk_en,
  output logic                      proc_clk_en,
  output logic [$clog2(PHASES)-1:0] phase,
  output logic                      running,
  output logic [CYC_W-1:0]          tick_count,
  output logic                      step_ack
);

  localparam int PW = $clog2(PHASES);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_HALTED = 2'd1,
    S_RUN    = 2'd2
`ifdef CLOCK_PHASE_GEN_STEP_EN
    ,S_STEP  = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [CYC_W-1:0] tick_q, tick_d;
  logic             pend_q, pend_d;
  logic             step_ack_q, step_ack_d;
  logic             active;
  logic             last_phase;

`ifndef CLOCK_PHASE_GEN_STEP_EN
  // Single-step is compiled out; the input is kept so both builds share one port list.
  logic unused_step_req;
  assign unused_step_req = step_req;
`endif

  // State registers with synchronous reset; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_HOLD;
      hold_q     <= HW'(RST_HOLD - 1);
      phase_q    <= '0;
      tick_q     <= '0;
      pend_q     <= 1'b0;
      step_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      pend_q     <= pend_d;
      step_ack_q <= step_ack_d;
    end
  end

  // Next-state logic and enable decode from state and phase.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    phase_d    = phase_q;
    tick_d     = tick_q;
    pend_d     = pend_q;
    step_ack_d = 1'b0;

    active = (state_q == S_RUN);
`ifdef CLOCK_PHASE_GEN_STEP_EN
    if (state_q == S_STEP) active = 1'b1;
`endif
    last_phase = (phase_q == LAST_PHASE);

    core_reset     = (state_q == S_HOLD);
    imem_clk_en    = active;
    dmem_clk_en    = active & phase_q[0];
    proc_clk_en    = active & last_phase;
    regfile_clk_en = active & last_phase;
    running        = active;

    if (proc_clk_en) tick_d = tick_q + CYC_W'(1);

    case (state_q)
      S_HOLD: begin
        if (hold_q == '0) state_d = S_HALTED;
        else              hold_d  = hold_q - HW'(1);
      end
      S_HALTED: begin
        phase_d = '0;
        pend_d  = 1'b0;
        if (run_req && !halt_req) state_d = S_RUN;
`ifdef CLOCK_PHASE_GEN_STEP_EN
        else if (step_req && !run_req && !halt_req) state_d = S_STEP;
`endif
      end
      S_RUN: begin
        // PHASES is a power of two, so the increment wraps to 0 by itself.
        phase_d = phase_q + PW'(1);
        if (last_phase) begin
          // Halt requests seen in this instruction take effect only at its end.
          if (pend_q || halt_req || !run_req) begin
            state_d = S_HALTED;
            phase_d = '0;
            pend_d  = 1'b0;
          end
        end else if (halt_req || !run_req) begin
          pend_d = 1'b1;
        end
      end
`ifdef CLOCK_PHASE_GEN_STEP_EN
      S_STEP: begin
        phase_d = phase_q + PW'(1);
        if (last_phase) begin
          state_d    = S_HALTED;
          phase_d    = '0;
          step_ack_d = 1'b1;
        end
      end
`endif
      default: state_d = S_HOLD;
    endcase
  end

  assign phase      = phase_q;
  assign tick_count = tick_q;
  assign step_ack   = step_ack_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed bench for clock_phase_gen with PHASES=4, RST_HOLD=8, CYC_W=4.
// Checks are made at the falling edge, inputs are driven there as well.
module tb_clock_phase_gen;

  logic       clock = 1'b0;
  logic       reset, run_req, halt_req, step_req;
  logic       core_reset, imem_clk_en, dmem_clk_en, regfile_clk_en, proc_clk_en;
  logic [1:0] phase;
  logic       running, step_ack;
  logic [3:0] tick_count;

  int total = 0;
  int bad   = 0;

  clock_phase_gen #(.PHASES(4), .RST_HOLD(8), .CYC_W(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .run_req        (run_req),
    .halt_req       (halt_req),
    .step_req       (step_req),
    .core_reset     (core_reset),
    .imem_clk_en    (imem_clk_en),
    .dmem_clk_en    (dmem_clk_en),
    .regfile_clk_en (regfile_clk_en),
    .proc_clk_en    (proc_clk_en),
    .phase          (phase),
    .running        (running),
    .tick_count     (tick_count),
    .step_ack       (step_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       run;
    logic       halt;
    logic       cr;
    logic       im;
    logic       dm;
    logic       pr;
    logic [1:0] ph;
    logic       rn;
    logic [3:0] tk;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_enables(input string tag);
    check({tag, " imem"}, imem_clk_en, 1'b0);
    check({tag, " dmem"}, dmem_clk_en, 1'b0);
    check({tag, " proc"}, proc_clk_en, 1'b0);
    check({tag, " regf"}, regfile_clk_en, 1'b0);
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  initial begin
    int tk0;
    int n_instr;
    logic [1:0] ph_v;

    // HALTED, run requested
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0};
    // Three full RUN instructions: dmem on odd phases, proc on phase 3
    for (int c = 0; c < 12; c++) begin
      ph_v = 2'(c % 4);
      vecs[1 + c] = '{1'b1, 1'b0, 1'b0, 1'b1, ph_v[0], (ph_v == 2'd3), ph_v, 1'b1, 4'(c / 4)};
    end
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'd3};
    // halt pulse at phase 1: instruction still completes
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 4'd3};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'd3};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 4'd3};
    // HALTED; run and halt together keep it halted
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd4};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd4};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd4};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd4};
    // run_req dropped at phase 1 halts at the instruction boundary
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'd4};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 4'd4};
    vecs[23] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'd4};
    vecs[24] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 4'd4};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd5};

    reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;

    // Reset held for two edges
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst core_reset", core_reset, 1'b1);
    check("rst phase", phase, 2'd0);
    check("rst tick", tick_count, 4'd0);
    check("rst running", running, 1'b0);
    check("rst step_ack", step_ack, 1'b0);
    check_idle_enables("rst");
    reset = 1'b0;

    // core_reset stays high for 8 cycles after release
    for (int i = 0; i < 8; i++) begin
      if (i > 0) sample();
      check($sformatf("hold%0d core_reset", i), core_reset, 1'b1);
      check_idle_enables($sformatf("hold%0d", i));
    end
    sample();
    check("hold done core_reset", core_reset, 1'b0);
    check_idle_enables("halted");
    check("halted running", running, 1'b0);

    // Table-driven RUN / halt sequences
    for (int v = 0; v < 26; v++) begin
      @(negedge clock);
      run_req  = vecs[v].run;
      halt_req = vecs[v].halt;
      #1;
      check($sformatf("v%0d core_reset", v), core_reset, vecs[v].cr);
      check($sformatf("v%0d imem", v), imem_clk_en, vecs[v].im);
      check($sformatf("v%0d dmem", v), dmem_clk_en, vecs[v].dm);
      check($sformatf("v%0d proc", v), proc_clk_en, vecs[v].pr);
      check($sformatf("v%0d regf", v), regfile_clk_en, vecs[v].pr);
      check($sformatf("v%0d phase", v), phase, vecs[v].ph);
      check($sformatf("v%0d running", v), running, vecs[v].rn);
      check($sformatf("v%0d tick", v), tick_count, vecs[v].tk);
      check($sformatf("v%0d step_ack", v), step_ack, 1'b0);
    end
    halt_req = 1'b0;
    run_req  = 1'b0;

    // Single step from HALTED; a second step_req during STEP is ignored
    @(negedge clock);
    step_req = 1'b1;
    #1;
    check("step pre running", running, 1'b0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      step_req = (j == 1);
      #1;
`ifdef CLOCK_PHASE_GEN_STEP_EN
      check($sformatf("step%0d running", j), running, (j < 4));
      check($sformatf("step%0d phase", j), phase, (j < 4) ? 2'(j) : 2'd0);
      check($sformatf("step%0d proc", j), proc_clk_en, (j == 3));
      check($sformatf("step%0d step_ack", j), step_ack, (j == 4));
      check($sformatf("step%0d tick", j), tick_count, (j < 4) ? 4'd5 : 4'd6);
`else
      check($sformatf("step%0d running", j), running, 1'b0);
      check($sformatf("step%0d phase", j), phase, 2'd0);
      check($sformatf("step%0d proc", j), proc_clk_en, 1'b0);
      check($sformatf("step%0d step_ack", j), step_ack, 1'b0);
      check($sformatf("step%0d tick", j), tick_count, 4'd5);
`endif
    end
    step_req = 1'b0;

`ifdef CLOCK_PHASE_GEN_STEP_EN
    tk0 = 6;
`else
    tk0 = 5;
`endif

    // Run until tick_count wraps 15 -> 0
    n_instr = 16 - tk0;
    @(negedge clock);
    run_req = 1'b1;
    #1;
    for (int s = 1; s <= 4 * n_instr + 7; s++) begin
      sample();
      if (s == 4 * n_instr) begin
        check("wrap pre tick", tick_count, 4'd15);
        check("wrap pre proc", proc_clk_en, 1'b1);
      end
      if (s == 4 * n_instr + 1) begin
        check("wrap tick", tick_count, 4'd0);
        check("wrap phase", phase, 2'd0);
      end
    end
    check("pre-reset phase", phase, 2'd2);
    check("pre-reset tick", tick_count, 4'd1);
    check("pre-reset running", running, 1'b1);

    // Reset mid-RUN at phase 2 with run_req still high
    reset = 1'b1;
    sample();
    check("midrst core_reset", core_reset, 1'b1);
    check("midrst tick", tick_count, 4'd0);
    check("midrst phase", phase, 2'd0);
    check("midrst running", running, 1'b0);
    check_idle_enables("midrst");
    reset = 1'b0;
    for (int i = 1; i < 8; i++) begin
      sample();
      check($sformatf("rehold%0d core_reset", i), core_reset, 1'b1);
      check($sformatf("rehold%0d imem", i), imem_clk_en, 1'b0);
    end
    sample();
    check("rehold done core_reset", core_reset, 1'b0);
    check("rehold done running", running, 1'b0);
    sample();
    check("rerun running", running, 1'b1);
    check("rerun phase", phase, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
